// File: rtl/dmem_arbiter.sv
// Two-requester arbiter/sequencer for the single-ported data memory.
// Each access walks IDLE -> ISSUE -> CAPT -> RESP, with one memory strobe per access.
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int FIX_PRIO = 0
) (
  input  logic              clock,
  input  logic              reset0,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic              busy,
  output logic              mem_visit,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_outp,
  input  logic              mem_valid
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, RESP} state_t;

  state_t            state;
  logic              win;
  logic              rr_ptr;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              grant_any;
  logic              grant_id;

  always_comb begin
    grant_any = req0 | req1;
    grant_id  = 1'b0;
    if (req0 && req1)
      grant_id = (FIX_PRIO != 0) ? 1'b0 : rr_ptr;
    else
      grant_id = req1;
  end

  // Reset gates the strobe combinationally so a reset landing in ISSUE never writes.
  assign mem_visit = (state == ISSUE) && !reset0;
  assign mem_we    = lat_we;
  assign mem_addr  = lat_addr;
  assign mem_data  = lat_wdata;

  always_ff @(posedge clock) begin
    if (reset0) begin
      state  <= IDLE;
      win    <= 1'b0;
      rr_ptr <= 1'b0;
      busy   <= 1'b0;
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      err0   <= 1'b0;
      err1   <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            win   <= grant_id;
            busy  <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: state <= CAPT;
        CAPT: begin
          // Memory output was updated at the ISSUE edge; capture it for the winner.
          if (win) begin
            ack1   <= 1'b1;
            rdata1 <= mem_outp;
            err1   <= ~mem_valid;
          end else begin
            ack0   <= 1'b1;
            rdata0 <= mem_outp;
            err0   <= ~mem_valid;
          end
          rr_ptr <= ~win;
          state  <= RESP;
        end
        RESP: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request fields are captured once at grant and held for the whole access.
  always_ff @(posedge clock) begin
    if (state == IDLE && grant_any) begin
      lat_we    <= grant_id ? we1 : we0;
      lat_addr  <= grant_id ? addr1 : addr0;
      lat_wdata <= grant_id ? wdata1 : wdata0;
    end
  end

endmodule
